sdram_arbiter: RTL and testbench
================================

Name: sdram_arbiter

Overview:
- Two-master arbiter and sequencer in front of the sdram_top controller on the board layer.
- Replaces the single-master reply logic with a registered FSM.
- Shares one SDRAM port between the CPU bus (m0) and a secondary requester (m1: DMA, disk buffer or video fetch).
- Converts Wishbone-style stb/we/sel/ack cycles into sdram_top req/ack pulses.
- Generates the DQM byte masks and holds read data for the granted master.

Parameters:
- ADR_W, 21, word-address width (bits [ADR_W:1] of the byte address).
- DAT_W, 16, data width.

Ports:
- clk  in  1  system clock; same net as the SDRAM controller clock.
- rst_n  in  1  asynchronous active-low reset.
- sdram_ready  in  1  controller init-done flag.
- m0_stb, m1_stb  in  1  master cycle strobes.
- m0_we, m1_we  in  1  write enables.
- m0_sel, m1_sel  in  2  byte selects.
- m0_adr, m1_adr  in  ADR_W  word addresses.
- m0_dat_o, m1_dat_o  in  DAT_W  master write data.
- m0_ack, m1_ack  out  1  cycle acknowledges.
- m_dat_i  out  DAT_W  read data, shared by both masters.
- sd_wr_req, sd_rd_req  out  1  controller requests.
- sd_wr_ack, sd_rd_ack  in  1  controller acknowledges.
- sd_addr  out  ADR_W+1  address to the controller: {1'b0, adr}.
- sd_wdata  out  DAT_W  write data to the controller.
- sd_rdata  in  DAT_W  read data from the controller.
- sd_byteen  out  2  byte enables to the controller.
- dqm_h, dqm_l  out  1  DRAM UDQM/LDQM.
- grant  out  1  owner of the current/last cycle: 0 = m0, 1 = m1.

Behaviour:
- Reset values (async, rst_n low):
  - state = IDLE.
  - All req, ack and dqm outputs 0.
  - m_dat_i = 0; grant = 0; sd_addr, sd_wdata, sd_byteen = 0.
- States: IDLE, ACCESS, REPLY, DRAIN.
- IDLE:
  - No grant while sdram_ready = 0.
  - Otherwise, on a sampled stb, pick a winner. Default is fixed priority: m0 beats m1.
  - Latch the winner's we, sel, adr and write data into sd_addr, sd_wdata and sd_byteen.
  - dqm_h/dqm_l: {~sel[1], ~sel[0]} for writes; 0/0 for reads.
  - Set grant and go to ACCESS.
  - Requests are registered: stb sampled at edge N gives sd_*_req high from N+1.
- ACCESS:
  - Hold sd_wr_req (we = 1) or sd_rd_req (we = 0) until the matching sd_*_ack is sampled high.
  - On that edge, drop the request. For reads, also capture sd_rdata into m_dat_i.
  - Then go to REPLY if the granted stb is still high, else DRAIN.
  - The non-matching ack is ignored.
- REPLY:
  - Internal reply flag = 1. mX_ack = reply & mX_stb & (grant == X), i.e. combinational gating of the registered flag.
  - First ack is visible one cycle after the controller ack.
  - Stay in REPLY while the granted stb is high.
  - When stb drops, clear reply and go to IDLE. This leaves one dead cycle before the next grant.
- DRAIN:
  - Entered when the master abandoned the cycle after the request was issued.
  - The transaction is not aborted. No ack is given. Go to IDLE next cycle.
- The losing master's stb is held pending, and it is served on the next IDLE arbitration.
- Latched inputs: address, data and sel are latched at grant. Changes during ACCESS are ignored.
- Simultaneous stb in IDLE: m0 wins (default).
- sdram_ready deasserting mid-cycle: the current cycle completes and further grants are blocked.
- rst_n low mid-operation: immediate return to reset values. The controller is reset on the same net.
- m_dat_i holds its last read value across writes.

Optional Feature:
- Macro SDRAM_ARB_RR_EN.
- Defined:
  - Round-robin arbitration. A last-winner register (reset 1, so m0 wins first) gives priority to the master that did not win last, on simultaneous requests only.
  - A lone requester is always granted.
- Undefined:
  - Fixed priority, m0 always first. No last-winner register is synthesised.

Decomposition:
- Shared package/include holds:
  - state encodings ST_IDLE = 2'd0, ST_ACCESS = 2'd1, ST_REPLY = 2'd2, ST_DRAIN = 2'd3;
  - ADR_W / DAT_W defaults.
- One natural sub-module, sdram_arb_pick: combinational winner select (stb0, stb1, last) -> (valid, id), with the RR/fixed choice under the macro.
- Everything else is flat in sdram_arbiter.

Test Plan:
- m0 read of adr 0x00100:
  - sd_rd_req rises 1 cycle after stb.
  - Model returns sd_rd_ack plus 0xA5A5 after 4 cycles.
  - m0_ack high the next cycle, m_dat_i = 0xA5A5, dqm = 0/0.
  - ack drops the cycle stb drops.
- m1 byte write, sel = 2'b10, data 0x12FF, adr 0x1FFFFF:
  - sd_wr_req high, sd_addr = 0x01FFFFF, dqm_h = 0, dqm_l = 1, sd_byteen = 2'b10.
  - m1_ack after sd_wr_ack; m0_ack stays 0.
- m0 and m1 stb raised on the same edge, both held:
  - Fixed: m0 served, then m1 after one dead cycle.
  - With SDRAM_ARB_RR_EN: repeat the collision 4 times; grant alternates 0,1,0,1.
- sdram_ready = 0 with m0_stb high for 20 cycles: no sd_*_req. Raise ready: request within 2 cycles.
- m1 drops stb 2 cycles into ACCESS:
  - sd_wr_req stays high until sd_wr_ack, then DRAIN. No m1_ack ever.
  - A pending m0 request is granted afterwards.
- rst_n pulsed low while in ACCESS: all outputs 0 asynchronously (before the next clk edge); state IDLE after release; a fresh m0 read then completes normally.

Source files
------------

// File: rtl/sdram_arbiter_pkg.sv
// Shared types and defaults for the two-master SDRAM arbiter.
package sdram_arbiter_pkg;

  localparam int ADR_W_DEF = 21;
  localparam int DAT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_REPLY  = 2'd2,
    ST_DRAIN  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/sdram_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the sdram_top controller.
interface sdram_arbiter_if import sdram_arbiter_pkg::*; #(
  parameter int ADR_W = ADR_W_DEF,
  parameter int DAT_W = DAT_W_DEF
);
  logic             sdram_ready;
  logic             m0_stb, m1_stb;
  logic             m0_we, m1_we;
  logic [1:0]       m0_sel, m1_sel;
  logic [ADR_W-1:0] m0_adr, m1_adr;
  logic [DAT_W-1:0] m0_dat_o, m1_dat_o;
  logic             m0_ack, m1_ack;
  logic [DAT_W-1:0] m_dat_i;
  logic             sd_wr_req, sd_rd_req;
  logic             sd_wr_ack, sd_rd_ack;
  logic [ADR_W:0]   sd_addr;
  logic [DAT_W-1:0] sd_wdata;
  logic [DAT_W-1:0] sd_rdata;
  logic [1:0]       sd_byteen;
  logic             dqm_h, dqm_l;
  logic             grant;

  modport slave (
    input  sdram_ready, m0_stb, m1_stb, m0_we, m1_we, m0_sel, m1_sel,
           m0_adr, m1_adr, m0_dat_o, m1_dat_o, sd_wr_ack, sd_rd_ack, sd_rdata,
    output m0_ack, m1_ack, m_dat_i, sd_wr_req, sd_rd_req, sd_addr, sd_wdata,
           sd_byteen, dqm_h, dqm_l, grant
  );

  modport master (
    output sdram_ready, m0_stb, m1_stb, m0_we, m1_we, m0_sel, m1_sel,
           m0_adr, m1_adr, m0_dat_o, m1_dat_o, sd_wr_ack, sd_rd_ack, sd_rdata,
    input  m0_ack, m1_ack, m_dat_i, sd_wr_req, sd_rd_req, sd_addr, sd_wdata,
           sd_byteen, dqm_h, dqm_l, grant
  );

endinterface

// File: rtl/sdram_arb_pick.sv
// Combinational winner select; SDRAM_ARB_RR_EN selects round-robin, else fixed m0 priority.
module sdram_arb_pick (
  input  logic stb0_i,
  input  logic stb1_i,
  input  logic last_i,
  output logic valid_o,
  output logic id_o
);

  assign valid_o = stb0_i | stb1_i;

`ifdef SDRAM_ARB_RR_EN
  // On a collision the master that did not win last goes first.
  assign id_o = (stb0_i & stb1_i) ? ~last_i : stb1_i;
`else
  logic unused_last;
  assign unused_last = last_i;
  assign id_o        = stb1_i & ~stb0_i;
`endif

endmodule

// File: rtl/sdram_arbiter.sv
// Two-master arbiter/sequencer in front of sdram_top. Optional macro: SDRAM_ARB_RR_EN (round-robin).
module sdram_arbiter import sdram_arbiter_pkg::*; #(
  parameter int ADR_W = ADR_W_DEF,
  parameter int DAT_W = DAT_W_DEF
) (
  input logic            clk,
  input logic            rst_n,
  sdram_arbiter_if.slave bus
);

  arb_state_e       state_q, state_d;
  logic             grant_q, grant_d;
  logic             we_q, we_d;
  logic             wr_req_q, wr_req_d;
  logic             rd_req_q, rd_req_d;
  logic             reply_q, reply_d;
  logic             dqm_h_q, dqm_h_d;
  logic             dqm_l_q, dqm_l_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [DAT_W-1:0] wdata_q, wdata_d;
  logic [DAT_W-1:0] rdata_q, rdata_d;
  logic [1:0]       byteen_q, byteen_d;

  logic             pick_vld, pick_id, last_w;
  logic             win_we;
  logic [1:0]       win_sel;
  logic             gnt_stb;
  logic             acc_done;

`ifdef SDRAM_ARB_RR_EN
  logic last_q, last_d;

  // Reset to 1 so m0 wins the first collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end
  assign last_w = last_q;
`else
  assign last_w = 1'b0;
`endif

  sdram_arb_pick u_pick (
    .stb0_i  (bus.m0_stb),
    .stb1_i  (bus.m1_stb),
    .last_i  (last_w),
    .valid_o (pick_vld),
    .id_o    (pick_id)
  );

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    we_d     = we_q;
    wr_req_d = wr_req_q;
    rd_req_d = rd_req_q;
    reply_d  = reply_q;
    dqm_h_d  = dqm_h_q;
    dqm_l_d  = dqm_l_q;
    adr_d    = adr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    byteen_d = byteen_q;
`ifdef SDRAM_ARB_RR_EN
    last_d   = last_q;
`endif
    win_we   = pick_id ? bus.m1_we  : bus.m0_we;
    win_sel  = pick_id ? bus.m1_sel : bus.m0_sel;
    gnt_stb  = grant_q ? bus.m1_stb : bus.m0_stb;
    acc_done = we_q ? bus.sd_wr_ack : bus.sd_rd_ack;

    case (state_q)
      ST_IDLE: begin
        if (bus.sdram_ready && pick_vld) begin
          grant_d  = pick_id;
          we_d     = win_we;
          adr_d    = pick_id ? bus.m1_adr : bus.m0_adr;
          wdata_d  = pick_id ? bus.m1_dat_o : bus.m0_dat_o;
          byteen_d = win_sel;
          dqm_h_d  = win_we & ~win_sel[1];
          dqm_l_d  = win_we & ~win_sel[0];
          wr_req_d = win_we;
          rd_req_d = ~win_we;
          state_d  = ST_ACCESS;
`ifdef SDRAM_ARB_RR_EN
          last_d   = pick_id;
`endif
        end
      end
      ST_ACCESS: begin
        // Only the ack matching the issued request ends the access.
        if (acc_done) begin
          wr_req_d = 1'b0;
          rd_req_d = 1'b0;
          if (!we_q) rdata_d = bus.sd_rdata;
          if (gnt_stb) begin
            reply_d = 1'b1;
            state_d = ST_REPLY;
          end else begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_REPLY: begin
        if (!gnt_stb) begin
          reply_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= 1'b0;
      we_q     <= 1'b0;
      wr_req_q <= 1'b0;
      rd_req_q <= 1'b0;
      reply_q  <= 1'b0;
      dqm_h_q  <= 1'b0;
      dqm_l_q  <= 1'b0;
      adr_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      byteen_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      we_q     <= we_d;
      wr_req_q <= wr_req_d;
      rd_req_q <= rd_req_d;
      reply_q  <= reply_d;
      dqm_h_q  <= dqm_h_d;
      dqm_l_q  <= dqm_l_d;
      adr_q    <= adr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      byteen_q <= byteen_d;
    end
  end

  // Ack follows the master's strobe combinationally so it drops the cycle stb drops.
  assign bus.m0_ack    = reply_q & bus.m0_stb & ~grant_q;
  assign bus.m1_ack    = reply_q & bus.m1_stb &  grant_q;
  assign bus.m_dat_i   = rdata_q;
  assign bus.sd_wr_req = wr_req_q;
  assign bus.sd_rd_req = rd_req_q;
  assign bus.sd_addr   = {1'b0, adr_q};
  assign bus.sd_wdata  = wdata_q;
  assign bus.sd_byteen = byteen_q;
  assign bus.dqm_h     = dqm_h_q;
  assign bus.dqm_l     = dqm_l_q;
  assign bus.grant     = grant_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: vector table, hand-written corner sequences and two random masters.
module tb_sdram_arbiter;
  import sdram_arbiter_pkg::*;

  localparam int AW = 21;
  localparam int DW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sdram_arbiter_if #(.ADR_W(AW), .DAT_W(DW)) bus ();
  sdram_arbiter #(.ADR_W(AW), .DAT_W(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                        input logic [1:0] be);
    merge = {be[1] ? d[15:8] : old[15:8], be[0] ? d[7:0] : old[7:0]};
  endfunction

  // SDRAM controller model: ack after ctl_lat cycles of request, backing memory sdmem.
  logic [15:0] sdmem  [int];
  logic [15:0] refmem [int];
  int ctl_lat = 4;
  bit rand_lat = 0;
  int ctl_cnt = 0;

  function automatic logic [15:0] mem_rd(input int a);
    mem_rd = sdmem.exists(a) ? sdmem[a] : 16'h0000;
  endfunction

  initial begin
    bus.sd_wr_ack = 1'b0;
    bus.sd_rd_ack = 1'b0;
    bus.sd_rdata  = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        bus.sd_wr_ack = 1'b0;
        bus.sd_rd_ack = 1'b0;
        ctl_cnt = 0;
      end else begin
        #1;
        if (bus.sd_wr_ack || bus.sd_rd_ack) begin
          bus.sd_wr_ack = 1'b0;
          bus.sd_rd_ack = 1'b0;
        end else if (bus.sd_wr_req || bus.sd_rd_req) begin
          ctl_cnt++;
          if (ctl_cnt >= ctl_lat) begin
            ctl_cnt = 0;
            if (bus.sd_wr_req) begin
              sdmem[int'(bus.sd_addr)] = merge(mem_rd(int'(bus.sd_addr)), bus.sd_wdata, bus.sd_byteen);
              bus.sd_wr_ack = 1'b1;
            end else begin
              bus.sd_rdata  = mem_rd(int'(bus.sd_addr));
              bus.sd_rd_ack = 1'b1;
            end
            if (rand_lat) ctl_lat = $urandom_range(1, 6);
          end
        end else begin
          ctl_cnt = 0;
        end
      end
    end
  end

  task automatic set_m(input logic m, input logic stb, input logic we, input logic [1:0] sel,
                       input logic [20:0] adr, input logic [15:0] dat);
    if (m) begin
      bus.m1_stb = stb; bus.m1_we = we; bus.m1_sel = sel; bus.m1_adr = adr; bus.m1_dat_o = dat;
    end else begin
      bus.m0_stb = stb; bus.m0_we = we; bus.m0_sel = sel; bus.m0_adr = adr; bus.m0_dat_o = dat;
    end
  endtask

  task automatic drop_stb(input logic m);
    if (m) bus.m1_stb = 1'b0;
    else   bus.m0_stb = 1'b0;
  endtask

  function automatic logic mack(input logic m);
    mack = m ? bus.m1_ack : bus.m0_ack;
  endfunction

  task automatic wait_ack(input logic m, input int budget, output bit got, output bit other_seen);
    got = 0;
    other_seen = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (mack(~m)) other_seen = 1;
      if (mack(m)) begin
        got = 1;
        break;
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ":m0_ack"}, bus.m0_ack, 0);
    check({tag, ":m1_ack"}, bus.m1_ack, 0);
    check({tag, ":m_dat_i"}, bus.m_dat_i, 0);
    check({tag, ":reqs"}, {bus.sd_wr_req, bus.sd_rd_req}, 0);
    check({tag, ":sd_addr"}, bus.sd_addr, 0);
    check({tag, ":sd_wdata"}, bus.sd_wdata, 0);
    check({tag, ":sd_byteen"}, bus.sd_byteen, 0);
    check({tag, ":dqm"}, {bus.dqm_h, bus.dqm_l}, 0);
    check({tag, ":grant"}, bus.grant, 0);
  endtask

  typedef struct {
    string       name;
    logic        m;
    logic        we;
    logic [1:0]  sel;
    logic [20:0] adr;
    logic [15:0] wdat;
    logic        pre;
    logic [15:0] preval;
    logic [21:0] x_addr;
    logic [1:0]  x_byteen;
    logic        x_dqmh;
    logic        x_dqml;
    logic [15:0] x_mdat;
  } vec_t;

  vec_t vecs[8];

  // Single transaction from one idle master, with its address/data scrambled after grant.
  task automatic run_vec(input vec_t v);
    bit got;
    if (v.pre) sdmem[int'({1'b0, v.adr})] = v.preval;
    @(negedge clk);
    set_m(v.m, 1'b1, v.we, v.sel, v.adr, v.wdat);
    check({v.name, ":no_req_yet"}, {bus.sd_wr_req, bus.sd_rd_req}, 0);
    @(negedge clk);
    check({v.name, ":req"}, {bus.sd_wr_req, bus.sd_rd_req}, v.we ? 2'b10 : 2'b01);
    check({v.name, ":grant"}, bus.grant, v.m);
    check({v.name, ":sd_addr"}, bus.sd_addr, v.x_addr);
    check({v.name, ":byteen"}, bus.sd_byteen, v.x_byteen);
    check({v.name, ":dqm"}, {bus.dqm_h, bus.dqm_l}, {v.x_dqmh, v.x_dqml});
    check({v.name, ":wdata"}, bus.sd_wdata, v.wdat);
    set_m(v.m, 1'b1, v.we, ~v.sel, ~v.adr, ~v.wdat);
    got = 0;
    for (int k = 0; k < 50; k++) begin
      if (bus.sd_wr_ack || bus.sd_rd_ack) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    check({v.name, ":ctl_ack"}, got, 1);
    check({v.name, ":ack_not_early"}, mack(v.m), 0);
    check({v.name, ":addr_latched"}, bus.sd_addr, v.x_addr);
    @(negedge clk);
    check({v.name, ":ack"}, mack(v.m), 1);
    check({v.name, ":other_ack"}, mack(~v.m), 0);
    check({v.name, ":m_dat_i"}, bus.m_dat_i, v.x_mdat);
    check({v.name, ":req_dropped"}, {bus.sd_wr_req, bus.sd_rd_req}, 0);
    drop_stb(v.m);
    #1;
    check({v.name, ":ack_drop"}, mack(v.m), 0);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic rand_master(input logic m, input logic [20:0] base, input int n);
    bit got, oth;
    logic we;
    logic [1:0] sel;
    logic [20:0] adr;
    logic [15:0] dat, expv;
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      we  = 1'($urandom_range(0, 1));
      sel = 2'($urandom);
      adr = base + 21'($urandom_range(0, 7));
      dat = 16'($urandom);
      set_m(m, 1'b1, we, sel, adr, dat);
      wait_ack(m, 300, got, oth);
      check(m ? "rnd1:ack" : "rnd0:ack", got, 1);
      if (got) begin
        check(m ? "rnd1:grant" : "rnd0:grant", bus.grant, m);
        expv = refmem.exists(int'(adr)) ? refmem[int'(adr)] : 16'h0000;
        if (we) refmem[int'(adr)] = merge(expv, dat, sel);
        else check(m ? "rnd1:rdata" : "rnd0:rdata", bus.m_dat_i, expv);
      end
      drop_stb(m);
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit got, oth, flag, w;
    logic exp_w;

    vecs[0] = '{"m0_rd_100",  1'b0, 1'b0, 2'b11, 21'h00100,  16'h0000, 1'b1, 16'hA5A5, 22'h000100, 2'b11, 1'b0, 1'b0, 16'hA5A5};
    vecs[1] = '{"m1_wr_hi",   1'b1, 1'b1, 2'b10, 21'h1FFFFF, 16'h12FF, 1'b0, 16'h0000, 22'h1FFFFF, 2'b10, 1'b0, 1'b1, 16'hA5A5};
    vecs[2] = '{"m0_wr_lo",   1'b0, 1'b1, 2'b01, 21'h0ABCD,  16'h3C3C, 1'b0, 16'h0000, 22'h00ABCD, 2'b01, 1'b1, 1'b0, 16'hA5A5};
    vecs[3] = '{"m1_rd_hi",   1'b1, 1'b0, 2'b01, 21'h1FFFFF, 16'h0000, 1'b0, 16'h0000, 22'h1FFFFF, 2'b01, 1'b0, 1'b0, 16'h1200};
    vecs[4] = '{"m0_wr_all",  1'b0, 1'b1, 2'b11, 21'h0ABCD,  16'hBEEF, 1'b0, 16'h0000, 22'h00ABCD, 2'b11, 1'b0, 1'b0, 16'h1200};
    vecs[5] = '{"m0_rd_abcd", 1'b0, 1'b0, 2'b00, 21'h0ABCD,  16'h0000, 1'b0, 16'h0000, 22'h00ABCD, 2'b00, 1'b0, 1'b0, 16'hBEEF};
    vecs[6] = '{"m1_wr_none", 1'b1, 1'b1, 2'b00, 21'h00100,  16'hFFFF, 1'b0, 16'h0000, 22'h000100, 2'b00, 1'b1, 1'b1, 16'hBEEF};
    vecs[7] = '{"m1_rd_100",  1'b1, 1'b0, 2'b11, 21'h00100,  16'h0000, 1'b0, 16'h0000, 22'h000100, 2'b11, 1'b0, 1'b0, 16'hA5A5};

    bus.sdram_ready = 1'b1;
    set_m(1'b0, 1'b0, 1'b0, 2'b00, '0, '0);
    set_m(1'b1, 1'b0, 1'b0, 2'b00, '0, '0);
    #1 rst_n = 1'b0;
    #2 check_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Collision with both held: m0 first, then m1 after one dead cycle.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    sdmem[32'h10] = 16'h1111;
    sdmem[32'h20] = 16'h2222;
    @(negedge clk);
    set_m(1'b0, 1'b1, 1'b0, 2'b11, 21'h10, 16'h0);
    set_m(1'b1, 1'b1, 1'b0, 2'b11, 21'h20, 16'h0);
    @(negedge clk);
    check("coll:first_grant", bus.grant, 0);
    wait_ack(1'b0, 50, got, oth);
    check("coll:m0_ack", got, 1);
    check("coll:m1_no_ack", oth, 0);
    check("coll:m0_data", bus.m_dat_i, 16'h1111);
    drop_stb(1'b0);
    @(negedge clk);
    check("coll:dead_cycle", {bus.sd_rd_req, bus.grant}, 2'b00);
    @(negedge clk);
    check("coll:second_grant", {bus.sd_rd_req, bus.grant}, 2'b11);
    wait_ack(1'b1, 50, got, oth);
    check("coll:m1_ack", got, 1);
    check("coll:m1_data", bus.m_dat_i, 16'h2222);
    drop_stb(1'b1);
    @(negedge clk);

    // Repeated collisions where the loser withdraws after the winner's ack.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_m(1'b0, 1'b1, 1'b0, 2'b11, 21'h10, 16'h0);
      set_m(1'b1, 1'b1, 1'b0, 2'b11, 21'h20, 16'h0);
      got = 0;
      w = 0;
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (bus.m0_ack || bus.m1_ack) begin
          got = 1;
          w = bus.m1_ack;
          break;
        end
      end
`ifdef SDRAM_ARB_RR_EN
      exp_w = 1'(i % 2);
`else
      exp_w = 1'b0;
`endif
      check("rep:ack", got, 1);
      check("rep:winner", w, exp_w);
      check("rep:grant", bus.grant, exp_w);
      check("rep:data", bus.m_dat_i, exp_w ? 16'h2222 : 16'h1111);
      drop_stb(1'b0);
      drop_stb(1'b1);
      @(negedge clk);
    end

    // No grant while the controller is not ready.
    @(negedge clk);
    bus.sdram_ready = 1'b0;
    set_m(1'b0, 1'b1, 1'b0, 2'b11, 21'h00100, 16'h0);
    flag = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.sd_wr_req || bus.sd_rd_req) flag = 1;
    end
    check("notready:no_req", flag, 0);
    bus.sdram_ready = 1'b1;
    flag = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.sd_rd_req) flag = 1;
    end
    check("ready:req", flag, 1);
    wait_ack(1'b0, 50, got, oth);
    check("ready:ack", got, 1);
    drop_stb(1'b0);
    @(negedge clk);

    // m1 abandons its write inside ACCESS while m0 waits.
    @(negedge clk);
    set_m(1'b1, 1'b1, 1'b1, 2'b11, 21'h00003, 16'h5555);
    @(negedge clk);
    check("drain:wr_req", {bus.sd_wr_req, bus.grant}, 2'b11);
    set_m(1'b0, 1'b1, 1'b0, 2'b11, 21'h00100, 16'h0);
    @(negedge clk);
    drop_stb(1'b1);
    flag = 0;
    got = 0;
    oth = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.m1_ack) oth = 1;
      if (bus.sd_wr_ack) begin
        got = 1;
        break;
      end
      if (!bus.sd_wr_req) flag = 1;
    end
    check("drain:ctl_ack", got, 1);
    check("drain:req_held", flag, 0);
    @(negedge clk);
    check("drain:req_dropped", bus.sd_wr_req, 0);
    if (bus.m1_ack) oth = 1;
    wait_ack(1'b0, 50, got, w);
    if (w) oth = 1;
    check("drain:no_m1_ack", oth, 0);
    check("drain:m0_ack", got, 1);
    check("drain:m0_grant", bus.grant, 0);
    check("drain:m0_data", bus.m_dat_i, 16'hA5A5);
    check("drain:write_done", mem_rd(32'h3), 16'h5555);
    drop_stb(1'b0);
    @(negedge clk);

    // Asynchronous reset while a write is in ACCESS.
    @(negedge clk);
    set_m(1'b0, 1'b1, 1'b1, 2'b01, 21'h01234, 16'hCAFE);
    @(negedge clk);
    check("rst:in_access", {bus.sd_wr_req, bus.dqm_h}, 2'b11);
    #2 rst_n = 1'b0;
    #1 check_zero("rst_mid");
    drop_stb(1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst:idle_after", {bus.sd_wr_req, bus.sd_rd_req, bus.grant}, 0);
    run_vec(vecs[0]);

    // Two independent random masters on disjoint address regions.
    rand_lat = 1;
    fork
      rand_master(1'b0, 21'h00040, 25);
      rand_master(1'b1, 21'h01000, 25);
    join
    rand_lat = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
